// File: rtl/spi_reg_bank.sv
// rtl/spi_reg_bank.sv - SPI-slave register bank oversampled in the clk domain
module spi_reg_bank #(
    parameter int                            DATA_W   = 32,
    parameter int                            NUM_REGS = 4,
    parameter int                            CPOL     = 0,
    parameter int                            CPHA     = 0,
    parameter logic [NUM_REGS*DATA_W-1:0]    RST_VAL  = '0,
    parameter logic [NUM_REGS-1:0]           RO_MASK  = '0
) (
    input  logic                          clk,
    input  logic                          resetb,
    input  logic                          spi_sck,
    input  logic                          spi_cs_n,
    input  logic                          spi_mosi,
    output logic                          spi_miso,
    output logic                          spi_miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]    reg_q,
    input  logic [NUM_REGS*DATA_W-1:0]    status_in,
    output logic [NUM_REGS-1:0]           wr_strobe,
    output logic                          frame_err
);

    localparam int              CNT_W       = 6;
    localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(7);
    localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(DATA_W - 1);
    localparam logic [7:0]      NREGS8      = 8'(NUM_REGS);
    localparam logic [6:0]      LAST_ADDR   = 7'(NUM_REGS - 1);
    localparam logic            SCK_IDLE    = 1'(CPOL);
    localparam bit              SAMPLE_RISE = (CPOL == CPHA);
    localparam bit              CPHA1       = (CPHA != 0);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_WDATA, S_RDATA} state_t;

    state_t                      state_q, state_d;
    logic                        sck_s1_q, sck_s2_q, sck_d_q;
    logic                        cs_s1_q, cs_s2_q, cs_d_q;
    logic                        mosi_s1_q, mosi_s2_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [DATA_W-1:0]           rx_q;
    logic [DATA_W-1:0]           tx_q;
    logic                        miso_q;
    logic [6:0]                  addr_q;
    logic                        commit_q, load_q;
    logic [NUM_REGS*DATA_W-1:0]  regs_q;
    logic [NUM_REGS-1:0]         wr_strobe_q;
    logic                        frame_err_q;

    logic                        sck_rise, sck_fall, sample_ev, shift_ev, cs_fall;
    logic                        active, sample_go, shift_go, word_end, abort;
    logic [7:0]                  cmd_byte;
    logic                        in_range;
    logic [6:0]                  addr_inc;
    logic [DATA_W-1:0]           rd_word;
    logic [NUM_REGS-1:0]         wr_hit;

    // cs_n synchroniser resets to "selected" so a cs_n already low after reset is not seen as a new frame
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            sck_s1_q  <= SCK_IDLE;
            sck_s2_q  <= SCK_IDLE;
            sck_d_q   <= SCK_IDLE;
            cs_s1_q   <= 1'b0;
            cs_s2_q   <= 1'b0;
            cs_d_q    <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
        end else begin
            sck_s1_q  <= spi_sck;
            sck_s2_q  <= sck_s1_q;
            sck_d_q   <= sck_s2_q;
            cs_s1_q   <= spi_cs_n;
            cs_s2_q   <= cs_s1_q;
            cs_d_q    <= cs_s2_q;
            mosi_s1_q <= spi_mosi;
            mosi_s2_q <= mosi_s1_q;
        end
    end

    assign sck_rise  = sck_s2_q & ~sck_d_q;
    assign sck_fall  = ~sck_s2_q & sck_d_q;
    assign sample_ev = SAMPLE_RISE ? sck_rise : sck_fall;
    assign shift_ev  = SAMPLE_RISE ? sck_fall : sck_rise;
    assign cs_fall   = cs_d_q & ~cs_s2_q;

    assign active    = (state_q != S_IDLE) && !cs_s2_q;
    assign sample_go = active && sample_ev;
    assign word_end  = sample_go && ((state_q == S_CMD) ? (cnt_q == LAST_CMD) : (cnt_q == LAST_DATA));
    assign cmd_byte  = {rx_q[6:0], mosi_s2_q};
    assign abort     = (state_q != S_IDLE) && cs_s2_q && (cnt_q != '0);

    // A shift edge right after a word boundary (CPHA=0) belongs to the previous word; the MSB is already out
    assign shift_go  = active && (state_q == S_RDATA) && shift_ev && (CPHA1 || (cnt_q != '0));

    assign in_range  = ({1'b0, addr_q} < NREGS8);
    assign addr_inc  = !in_range ? addr_q : ((addr_q == LAST_ADDR) ? 7'd0 : addr_q + 7'd1);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (cs_s2_q) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (cs_fall) state_d = S_CMD;
                S_CMD:   if (word_end) state_d = cmd_byte[7] ? S_RDATA : S_WDATA;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        spi_miso_oe = 1'b0;
        spi_miso    = 1'b0;
        if ((state_q == S_RDATA) && !cs_s2_q) begin
            spi_miso_oe = 1'b1;
            spi_miso    = miso_q;
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            cnt_q    <= '0;
            rx_q     <= '0;
            addr_q   <= '0;
            commit_q <= 1'b0;
            load_q   <= 1'b0;
        end else begin
            commit_q <= word_end && (state_q == S_WDATA);
            load_q   <= word_end && ((state_q == S_RDATA) || ((state_q == S_CMD) && cmd_byte[7]));
            if (state_q == S_IDLE) begin
                cnt_q <= '0;
            end else if (sample_go) begin
                cnt_q <= word_end ? '0 : cnt_q + CNT_W'(1);
                rx_q  <= {rx_q[DATA_W-2:0], mosi_s2_q};
            end
            if (word_end && (state_q == S_CMD)) begin
                addr_q <= cmd_byte[6:0];
            end else if (commit_q || load_q) begin
                addr_q <= addr_inc;
            end
        end
    end

    always_comb begin
        rd_word = '0;
        wr_hit  = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr_q == 7'(i)) begin
                rd_word   = RO_MASK[i] ? status_in[i*DATA_W +: DATA_W] : regs_q[i*DATA_W +: DATA_W];
                wr_hit[i] = commit_q && !RO_MASK[i];
            end
        end
    end

    // Read-only slices are never written, so they stay at their reset value
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            regs_q      <= RST_VAL;
            wr_strobe_q <= '0;
        end else begin
            wr_strobe_q <= wr_hit;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) regs_q[i*DATA_W +: DATA_W] <= rx_q;
            end
        end
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            frame_err_q <= 1'b0;
        end else if (abort) begin
            frame_err_q <= 1'b1;
        end else if (commit_q && rx_q[0]) begin
            frame_err_q <= 1'b0;
        end
    end

    // CPHA=0 presents the MSB on load; CPHA=1 waits for the first leading (shift) edge
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            tx_q   <= '0;
            miso_q <= 1'b0;
        end else if (state_q == S_IDLE) begin
            miso_q <= 1'b0;
        end else if (load_q) begin
            if (CPHA1) begin
                tx_q <= rd_word;
            end else begin
                miso_q <= rd_word[DATA_W-1];
                tx_q   <= {rd_word[DATA_W-2:0], 1'b0};
            end
        end else if (shift_go) begin
            miso_q <= tx_q[DATA_W-1];
            tx_q   <= {tx_q[DATA_W-2:0], 1'b0};
        end
    end

    assign reg_q     = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// tb/tb_spi_reg_bank.sv - randomized bench for spi_reg_bank, one instance per SPI mode
module tb_spi_reg_bank;

    localparam logic [127:0] RST = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
    localparam int H = 60;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic [3:0]  sck = 4'b1100;
    logic [3:0]  cs_n = 4'b1111;
    logic        mosi = 1'b0;
    logic [127:0] status;
    wire  [3:0]  miso, oe, ferr;
    wire  [127:0] regq [4];
    wire  [3:0]  strobe [4];

    logic [127:0] rstv;
    logic [31:0]  mreg [4][4];
    logic         mferr [4];
    int           esc [4][4];
    int           scnt [4][4];
    logic [31:0]  wq [$];
    int           n_checks = 0;
    int           n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        spi_reg_bank #(
            .DATA_W(32), .NUM_REGS(4), .CPOL(g / 2), .CPHA(g % 2),
            .RST_VAL(RST), .RO_MASK(4'b0100)
        ) u_dut (
            .clk(clk), .resetb(resetb), .spi_sck(sck[g]), .spi_cs_n(cs_n[g]),
            .spi_mosi(mosi), .spi_miso(miso[g]), .spi_miso_oe(oe[g]),
            .reg_q(regq[g]), .status_in(status), .wr_strobe(strobe[g]), .frame_err(ferr[g])
        );
    end

    always @(negedge clk) begin
        for (int g = 0; g < 4; g++)
            for (int i = 0; i < 4; i++)
                if (strobe[g][i] === 1'b1) scnt[g][i]++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] nxt(input logic [6:0] a);
        return (a < 7'd4) ? ((a + 7'd1) % 7'd4) : a;
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 4; m++) begin
            for (int i = 0; i < 4; i++) mreg[m][i] = rstv[i*32 +: 32];
            mferr[m] = 1'b0;
        end
    endtask

    task automatic check_state(input int m);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("m%0d reg%0d", m, i), {32'b0, regq[m][i*32 +: 32]}, {32'b0, mreg[m][i]});
            chk($sformatf("m%0d strobes%0d", m, i), 64'(scnt[m][i]), 64'(esc[m][i]));
        end
        chk($sformatf("m%0d frame_err", m), {63'b0, ferr[m]}, {63'b0, mferr[m]});
        chk($sformatf("m%0d oe_idle", m), {62'b0, oe[m], miso[m]}, 64'd0);
    endtask

    task automatic xfer(input int m, input int n, input logic [63:0] dout, output logic [63:0] din);
        logic idle;
        idle = (m >= 2);
        din = '0;
        for (int i = n - 1; i >= 0; i--) begin
            if (m % 2 == 0) begin
                mosi = dout[i];
                #(H);
                din = {din[62:0], miso[m]};
                sck[m] = ~idle;
                #(H);
                sck[m] = idle;
            end else begin
                sck[m] = ~idle;
                mosi = dout[i];
                #(H);
                din = {din[62:0], miso[m]};
                sck[m] = idle;
                #(H);
            end
        end
    endtask

    task automatic cs_lo(input int m);
        @(negedge clk);
        cs_n[m] = 1'b0;
        #40;
    endtask

    task automatic cs_hi(input int m);
        #40;
        cs_n[m] = 1'b1;
        #120;
    endtask

    task automatic do_write(input int m, input logic [7:0] cmd);
        logic [63:0] d;
        logic [6:0]  a;
        cs_lo(m);
        xfer(m, 8, {56'b0, cmd}, d);
        a = cmd[6:0];
        foreach (wq[k]) begin
            xfer(m, 32, {32'b0, wq[k]}, d);
            if (a < 7'd4 && a != 7'd2) begin
                mreg[m][int'(a)] = wq[k];
                esc[m][int'(a)]++;
            end
            if (wq[k][0]) mferr[m] = 1'b0;
            a = nxt(a);
        end
        cs_hi(m);
        check_state(m);
    endtask

    task automatic do_read(input int m, input logic [7:0] cmd, input int nw);
        logic [63:0] d;
        logic [31:0] exp;
        logic [6:0]  a;
        cs_lo(m);
        xfer(m, 8, {56'b0, cmd}, d);
        chk($sformatf("m%0d oe_read", m), {63'b0, oe[m]}, 64'd1);
        a = cmd[6:0];
        for (int k = 0; k < nw; k++) begin
            xfer(m, 32, 64'd0, d);
            if (a >= 7'd4)      exp = 32'h0;
            else if (a == 7'd2) exp = status[64 +: 32];
            else                exp = mreg[m][int'(a)];
            chk($sformatf("m%0d rd cmd%0h w%0d", m, cmd, k), d, {32'b0, exp});
            a = nxt(a);
        end
        cs_hi(m);
        check_state(m);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] d;
        rstv = RST;
        status = {$urandom, 32'hCAFE0001, $urandom, $urandom};
        for (int m = 0; m < 4; m++)
            for (int i = 0; i < 4; i++) begin
                esc[m][i] = 0;
                scnt[m][i] = 0;
            end
        model_reset();
        repeat (4) @(negedge clk);
        for (int m = 0; m < 4; m++) begin
            check_state(m);
            chk($sformatf("m%0d strobe_rst", m), {60'b0, strobe[m]}, 64'd0);
        end
        resetb = 1'b1;
        repeat (4) @(negedge clk);

        wq = {32'hDEADBEEF};
        do_write(0, 8'h01);
        wq = {32'h11, 32'h22, 32'h33, 32'h44};
        do_write(0, 8'h00);
        do_read(0, 8'h83, 3);
        wq = {32'h0};
        do_write(0, 8'h02);
        do_read(0, 8'h82, 1);

        cs_lo(0);
        xfer(0, 8, 64'h00, d);
        xfer(0, 13, 64'h1ABC, d);
        cs_hi(0);
        mferr[0] = 1'b1;
        check_state(0);
        wq = {32'h0000_0001};
        do_write(0, 8'h00);

        for (int m = 0; m < 4; m++) begin
            wq = {$urandom};
            do_write(m, 8'h7F);
            do_read(m, 8'hFF, 1);
            wq = {32'hA5A5A5A5};
            do_write(m, 8'h03);
            do_read(m, 8'h83, 1);
            repeat (6) begin
                logic [7:0] cmd;
                int nw;
                cmd[6:0] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'($urandom_range(0, 3));
                cmd[7] = 1'($urandom_range(0, 1));
                nw = $urandom_range(1, 3);
                if (cmd[7]) begin
                    do_read(m, cmd, nw);
                end else begin
                    wq = {};
                    repeat (nw) wq.push_back($urandom);
                    do_write(m, cmd);
                end
            end
        end

        cs_lo(1);
        xfer(1, 8, 64'h03, d);
        xfer(1, 19, 64'h5_5555, d);
        resetb = 1'b0;
        #30;
        resetb = 1'b1;
        model_reset();
        xfer(1, 45, {$urandom, $urandom}, d);
        cs_hi(1);
        for (int m = 0; m < 4; m++) check_state(m);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
